decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised decode stage for the 16-bit core. It sits between fetch and execute and decodes one instruction per cycle behind a valid/ready handshake. The immediate width is configurable, and the block flags illegal opcodes and register-usage qualifiers. An 8-entry register scoreboard stalls issue on RAW/WAW hazards until the writeback port retires the producing register.

## Interface
- IMM_W, 16, width of sign-extended immediate output (legal: 16..32)
- SB_EN, 1, 1 = scoreboard hazard stalling enabled; 0 = hazard term forced to 0, pending bits never set
- ZERO_REG_EN, 1, 1 = register 0 is hardwired zero: never set pending, never causes a hazard

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- in_valid_i  in  1  fetch presents instr_i/pc_i
- in_ready_o  out  1  decode accepts this cycle
- instr_i  in  16  instruction word
- pc_i  in  16  instruction address
- flush_i  in  1  discard held instruction (branch redirect)
- out_valid_o  out  1  decoded instruction valid
- out_ready_i  in  1  execute accepts
- opcode_o  out  3  instr[2:0]
- rd_addr_o, rs1_addr_o, rs2_addr_o  out  3 each  register addresses
- func4_o  out  4  R-type function
- func2_o  out  2  I/L/S/B qualifier
- imm_data_o  out  IMM_W  sign-extended immediate
- pc_o  out  16  pc of held instruction
- rd_we_o, rs1_used_o, rs2_used_o  out  1 each  usage qualifiers
- illegal_o  out  1  opcode is not a riscv_pkg::opcode_t member
- wb_valid_i  in  1  writeback retiring wb_addr_i
- wb_addr_i  in  3  register being written back

## Operation
- Field decode uses opcode_t = instr[2:0]. Unused fields are 0.
  - R_OP: rd[5:3], rs1[8:6], rs2[11:9], func4[15:12]; rd_we, rs1_used, rs2_used.
  - I_OP, L_OP: rd[5:3], rs1[8:6], func2[10:9], imm = sext(instr[15:11]); rd_we, rs1_used.
  - S_OP, B_OP: rs1[8:6], rs2[5:3], func2[10:9], imm = sext(instr[15:11]); rs1_used, rs2_used.
  - J_OP: rd[5:3], imm = sext(instr[15:6]); rd_we.
  - JR_OP: rd[5:3], rs1[8:6], imm = sext(instr[15:10]); rd_we, rs1_used.
  - Any other code: illegal_o = 1, all other fields and qualifiers 0, opcode_o still = instr[2:0].
- Sign extension replicates instr[15] up to IMM_W.
- Output register: a single stage.
  - accept = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- in_ready_o = !flush_i & (!out_valid_o | out_ready_i) & !hazard.
- The scoreboard has pending[7:0].
  - A register is busy(r) when pending[r] & !(wb_valid_i & wb_addr_i == r), OR when the held instruction has out_valid_o & rd_we_o & rd_addr_o == r.
  - hazard = (rs1_used & busy(rs1)) | (rs2_used & busy(rs2)) | (rd_we & busy(rd)), evaluated on the incoming instruction.
  - With ZERO_REG_EN, busy(0) = 0.
- Pending update:
  - Set pending[rd_addr_o] on out_fire & rd_we_o.
  - Clear pending[wb_addr_i] on wb_valid_i.
  - Set and clear on the same register in the same cycle: set wins.
  - wb to a non-pending register: no effect.
  - Illegal instructions never set pending.
- Flush:
  - flush_i clears out_valid_o next cycle. The held instruction is not handed off and sets nothing.
  - Pending bits are unchanged, since those producers are already downstream.
  - in_ready_o = 0 during flush, so flush wins over accept.

## Timing
- Reset (async assert, sync-safe deassert):
  - out_valid_o = 0 and pending = 0.
  - All data outputs and qualifiers = 0, illegal_o = 0, pc_o = 0.
  - in_ready_o = 1 whenever in_valid_i = 0 or no hazard.
- Latency is 1 cycle: an instruction accepted at edge N is presented with out_valid_o = 1 after edge N.
- Throughput is 1 instruction/cycle when out_ready_i = 1 and there is no hazard.
- Outputs are registered and stable while out_valid_o & !out_ready_i. in_ready_o is combinational from in_valid_i/instr_i, out_ready_i, flush_i and wb inputs.
- A dependent consumer stalls while its producer is held or pending. It may be accepted in the same cycle wb_valid_i retires the producer (same-cycle bypass of the clear).
- Reset mid-stall drops the held instruction and clears all pending bits.

## Test plan
- Reset then stream: R_OP rd=3 rs1=1 rs2=2 func4=4'hA with out_ready_i=1 -> next cycle out_valid_o=1, rd=3, rs1=1, rs2=2, func4=4'hA, rd_we=1; back-to-back independent instructions at 1/cycle.
- Immediates at IMM_W=16 and IMM_W=32:
  - I_OP with instr[15:11]=5'b10000 -> imm=-16.
  - J_OP with instr[15:6]=10'h3FF -> imm=-1.
  - JR_OP with instr[15:10]=6'h1F -> imm=31.
- RAW stall: I_OP rd=5 issues; then B_OP rs1=5 -> in_ready_o=0 until wb_valid_i=1, wb_addr_i=5; accepted in that same cycle; pending[5]=0 after.
- Back-pressure: out_ready_i=0 for 4 cycles -> outputs held bit-stable, in_ready_o=0; a held R_OP rd=2 followed by consumer rs2=2 stays stalled after release until wb of 2.
- Flush with held valid J_OP rd=4 -> out_valid_o=0 next cycle, pending[4]=0, in_ready_o=0 in the flush cycle; illegal opcode -> illegal_o=1, rd_we=0, no pending set.
- Corners:
  - ZERO_REG_EN=1: rd=0 writes never stall.
  - SB_EN=0: no stalls regardless of dependencies.
  - Same-cycle out_fire setting r and wb clearing r -> pending[r]=1.
  - Async reset mid-stall -> all pending cleared.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute/writeback signal bundle for decode_stage.
// Signal names keep the decode stage's own _i/_o orientation so that the
// slave modport reads like the stage's port list. pending_o is a debug view
// of the register scoreboard.
interface decode_stage_if #(
    parameter int IMM_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [15:0]      instr_i;
    logic [15:0]      pc_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [2:0]       opcode_o;
    logic [2:0]       rd_addr_o;
    logic [2:0]       rs1_addr_o;
    logic [2:0]       rs2_addr_o;
    logic [3:0]       func4_o;
    logic [1:0]       func2_o;
    logic [IMM_W-1:0] imm_data_o;
    logic [15:0]      pc_o;
    logic             rd_we_o;
    logic             rs1_used_o;
    logic             rs2_used_o;
    logic             illegal_o;
    logic             wb_valid_i;
    logic [2:0]       wb_addr_i;
    logic [7:0]       pending_o;

    // Decode stage view.
    modport slave (
        input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
               wb_valid_i, wb_addr_i,
        output in_ready_o, out_valid_o, opcode_o, rd_addr_o, rs1_addr_o,
               rs2_addr_o, func4_o, func2_o, imm_data_o, pc_o, rd_we_o,
               rs1_used_o, rs2_used_o, illegal_o, pending_o
    );

    // Surrounding pipeline view (fetch, execute, writeback).
    modport master (
        output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
               wb_valid_i, wb_addr_i,
        input  in_ready_o, out_valid_o, opcode_o, rd_addr_o, rs1_addr_o,
               rs2_addr_o, func4_o, func2_o, imm_data_o, pc_o, rd_we_o,
               rs1_used_o, rs2_used_o, illegal_o, pending_o
    );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage for the 16-bit core: one instruction per cycle,
// field/immediate decode, illegal-opcode flag and an 8-entry scoreboard
// that stalls RAW/WAW hazards until writeback retires the producer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until that edge;
// ready may depend combinationally on valid and payload, valid never
// depends on ready. On the input side ready also drops for flush and hazards.
module decode_stage #(
    parameter int IMM_W       = 16,
    parameter bit SB_EN       = 1'b1,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    typedef enum logic [2:0] {
        R_OP  = 3'd0,
        I_OP  = 3'd1,
        L_OP  = 3'd2,
        S_OP  = 3'd3,
        B_OP  = 3'd4,
        J_OP  = 3'd5,
        JR_OP = 3'd6
    } opcode_t;

    // Combinational decode of the incoming instruction.
    logic [2:0]       dec_rd;
    logic [2:0]       dec_rs1;
    logic [2:0]       dec_rs2;
    logic [3:0]       dec_func4;
    logic [1:0]       dec_func2;
    logic [IMM_W-1:0] dec_imm;
    logic             dec_rd_we;
    logic             dec_rs1_used;
    logic             dec_rs2_used;
    logic             dec_illegal;

    // Held (output) instruction registers.
    logic             out_valid_q, out_valid_d;
    logic [2:0]       opcode_q;
    logic [2:0]       rd_q;
    logic [2:0]       rs1_q;
    logic [2:0]       rs2_q;
    logic [3:0]       func4_q;
    logic [1:0]       func2_q;
    logic [IMM_W-1:0] imm_q;
    logic [15:0]      pc_q;
    logic             rd_we_q;
    logic             rs1_used_q;
    logic             rs2_used_q;
    logic             illegal_q;

    // Scoreboard.
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       wb_clr;
    logic [7:0]       busy;
    logic             hazard;
    logic             in_ready;
    logic             accept;
    logic             out_fire;

    opcode_t          op;
    logic [15:0]      instr;

    assign instr = bus.instr_i;
    assign op    = opcode_t'(instr[2:0]);

    // Field decode; everything not used by the opcode stays 0.
    always_comb begin
        dec_rd       = 3'd0;
        dec_rs1      = 3'd0;
        dec_rs2      = 3'd0;
        dec_func4    = 4'd0;
        dec_func2    = 2'd0;
        dec_imm      = '0;
        dec_rd_we    = 1'b0;
        dec_rs1_used = 1'b0;
        dec_rs2_used = 1'b0;
        dec_illegal  = 1'b0;
        case (op)
            R_OP: begin
                dec_rd       = instr[5:3];
                dec_rs1      = instr[8:6];
                dec_rs2      = instr[11:9];
                dec_func4    = instr[15:12];
                dec_rd_we    = 1'b1;
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
            end
            I_OP, L_OP: begin
                dec_rd       = instr[5:3];
                dec_rs1      = instr[8:6];
                dec_func2    = instr[10:9];
                dec_imm      = {{(IMM_W-5){instr[15]}}, instr[15:11]};
                dec_rd_we    = 1'b1;
                dec_rs1_used = 1'b1;
            end
            S_OP, B_OP: begin
                dec_rs1      = instr[8:6];
                dec_rs2      = instr[5:3];
                dec_func2    = instr[10:9];
                dec_imm      = {{(IMM_W-5){instr[15]}}, instr[15:11]};
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
            end
            J_OP: begin
                dec_rd       = instr[5:3];
                dec_imm      = {{(IMM_W-10){instr[15]}}, instr[15:6]};
                dec_rd_we    = 1'b1;
            end
            JR_OP: begin
                dec_rd       = instr[5:3];
                dec_rs1      = instr[8:6];
                dec_imm      = {{(IMM_W-6){instr[15]}}, instr[15:10]};
                dec_rd_we    = 1'b1;
                dec_rs1_used = 1'b1;
            end
            default: begin
                dec_illegal  = 1'b1;
            end
        endcase
    end

    // Busy vector: pending minus a same-cycle writeback retire, plus the
    // held producer that has not yet reached the pending bits.
    always_comb begin
        wb_clr = 8'd0;
        if (bus.wb_valid_i) begin
            wb_clr[bus.wb_addr_i] = 1'b1;
        end
        busy = pending_q & ~wb_clr;
        if (out_valid_q && rd_we_q) begin
            busy[rd_q] = 1'b1;
        end
        if (ZERO_REG_EN) begin
            busy[0] = 1'b0;
        end
    end

    // Hazard check on the incoming instruction and the input-side handshake.
    always_comb begin
        hazard = 1'b0;
        if (SB_EN && bus.in_valid_i) begin
            hazard = (dec_rs1_used && busy[dec_rs1]) ||
                     (dec_rs2_used && busy[dec_rs2]) ||
                     (dec_rd_we    && busy[dec_rd]);
        end
        in_ready = !bus.flush_i && (!out_valid_q || bus.out_ready_i) && !hazard;
    end

    assign accept   = bus.in_valid_i && in_ready;
    assign out_fire = out_valid_q && bus.out_ready_i;

    // Next state of the held-valid flag: flush drops, accept loads, fire empties.
    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Pending update: retire on writeback, set on hand-off (set wins).
    always_comb begin
        pending_d = pending_q & ~wb_clr;
        if (SB_EN && out_fire && !bus.flush_i && rd_we_q &&
            !(ZERO_REG_EN && rd_q == 3'd0)) begin
            pending_d[rd_q] = 1'b1;
        end
    end

    // Output register stage and scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= 3'd0;
            rd_q        <= 3'd0;
            rs1_q       <= 3'd0;
            rs2_q       <= 3'd0;
            func4_q     <= 4'd0;
            func2_q     <= 2'd0;
            imm_q       <= '0;
            pc_q        <= 16'd0;
            rd_we_q     <= 1'b0;
            rs1_used_q  <= 1'b0;
            rs2_used_q  <= 1'b0;
            illegal_q   <= 1'b0;
            pending_q   <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            if (accept) begin
                opcode_q   <= instr[2:0];
                rd_q       <= dec_rd;
                rs1_q      <= dec_rs1;
                rs2_q      <= dec_rs2;
                func4_q    <= dec_func4;
                func2_q    <= dec_func2;
                imm_q      <= dec_imm;
                pc_q       <= bus.pc_i;
                rd_we_q    <= dec_rd_we;
                rs1_used_q <= dec_rs1_used;
                rs2_used_q <= dec_rs2_used;
                illegal_q  <= dec_illegal;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.opcode_o    = opcode_q;
    assign bus.rd_addr_o   = rd_q;
    assign bus.rs1_addr_o  = rs1_q;
    assign bus.rs2_addr_o  = rs2_q;
    assign bus.func4_o     = func4_q;
    assign bus.func2_o     = func2_q;
    assign bus.imm_data_o  = imm_q;
    assign bus.pc_o        = pc_q;
    assign bus.rd_we_o     = rd_we_q;
    assign bus.rs1_used_o  = rs1_used_q;
    assign bus.rs2_used_o  = rs2_used_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.pending_o   = pending_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: three instances share one stimulus
// stream (IMM_W=16 reference, IMM_W=32, and scoreboard disabled).
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        flush;
  logic        out_ready;
  logic        wb_valid;
  logic [2:0]  wb_addr;

  int total;
  int bad;

  decode_stage_if #(.IMM_W(16)) bus_a ();
  decode_stage_if #(.IMM_W(32)) bus_w ();
  decode_stage_if #(.IMM_W(16)) bus_n ();

  assign bus_a.in_valid_i  = in_valid;
  assign bus_a.instr_i     = instr;
  assign bus_a.pc_i        = pc;
  assign bus_a.flush_i     = flush;
  assign bus_a.out_ready_i = out_ready;
  assign bus_a.wb_valid_i  = wb_valid;
  assign bus_a.wb_addr_i   = wb_addr;

  assign bus_w.in_valid_i  = in_valid;
  assign bus_w.instr_i     = instr;
  assign bus_w.pc_i        = pc;
  assign bus_w.flush_i     = flush;
  assign bus_w.out_ready_i = out_ready;
  assign bus_w.wb_valid_i  = wb_valid;
  assign bus_w.wb_addr_i   = wb_addr;

  assign bus_n.in_valid_i  = in_valid;
  assign bus_n.instr_i     = instr;
  assign bus_n.pc_i        = pc;
  assign bus_n.flush_i     = flush;
  assign bus_n.out_ready_i = out_ready;
  assign bus_n.wb_valid_i  = wb_valid;
  assign bus_n.wb_addr_i   = wb_addr;

  decode_stage #(.IMM_W(16), .SB_EN(1'b1), .ZERO_REG_EN(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  decode_stage #(.IMM_W(32), .SB_EN(1'b1), .ZERO_REG_EN(1'b1)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  decode_stage #(.IMM_W(16), .SB_EN(1'b0), .ZERO_REG_EN(1'b1)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    instr     = 16'h0000;
    pc        = 16'h0000;
    flush     = 1'b0;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_addr   = 3'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // ---- reset state
    chk("rst_out_valid", bus_a.out_valid_o, 0);
    chk("rst_pending",   bus_a.pending_o, 0);
    chk("rst_rd",        bus_a.rd_addr_o, 0);
    chk("rst_imm",       bus_a.imm_data_o, 0);
    chk("rst_illegal",   bus_a.illegal_o, 0);
    chk("rst_pc",        bus_a.pc_o, 0);
    chk("rst_rd_we",     bus_a.rd_we_o, 0);
    chk("rst_in_ready",  bus_a.in_ready_o, 1);
    rst_n = 1'b1;

    // ---- stream: R rd=3 rs1=1 rs2=2 func4=A
    in_valid = 1'b1; instr = 16'hA458; pc = 16'h0100;
    #1 chk("r_in_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("r_out_valid", bus_a.out_valid_o, 1);
    chk("r_opcode",    bus_a.opcode_o, 0);
    chk("r_rd",        bus_a.rd_addr_o, 3);
    chk("r_rs1",       bus_a.rs1_addr_o, 1);
    chk("r_rs2",       bus_a.rs2_addr_o, 2);
    chk("r_func4",     bus_a.func4_o, 4'hA);
    chk("r_func2",     bus_a.func2_o, 0);
    chk("r_imm",       bus_a.imm_data_o, 0);
    chk("r_rd_we",     bus_a.rd_we_o, 1);
    chk("r_rs1_used",  bus_a.rs1_used_o, 1);
    chk("r_rs2_used",  bus_a.rs2_used_o, 1);
    chk("r_pc",        bus_a.pc_o, 16'h0100);
    // I rd=6 rs1=7 func2=2 imm5=10000 back to back
    instr = 16'h85F1; pc = 16'h0102;
    #1 chk("i_in_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("i_out_valid", bus_a.out_valid_o, 1);
    chk("i_opcode",    bus_a.opcode_o, 1);
    chk("i_rd",        bus_a.rd_addr_o, 6);
    chk("i_rs1",       bus_a.rs1_addr_o, 7);
    chk("i_rs2",       bus_a.rs2_addr_o, 0);
    chk("i_func2",     bus_a.func2_o, 2);
    chk("i_imm16",     bus_a.imm_data_o, 16'hFFF0);
    chk("i_imm32",     bus_w.imm_data_o, 32'hFFFF_FFF0);
    chk("i_rs2_used",  bus_a.rs2_used_o, 0);
    chk("i_pending",   bus_a.pending_o, 8'h08);
    // J rd=1 imm10=3FF
    instr = 16'hFFCD; pc = 16'h0104;
    #1 chk("j_in_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("j_opcode",    bus_a.opcode_o, 5);
    chk("j_rd",        bus_a.rd_addr_o, 1);
    chk("j_imm16",     bus_a.imm_data_o, 16'hFFFF);
    chk("j_imm32",     bus_w.imm_data_o, 32'hFFFF_FFFF);
    chk("j_rs1_used",  bus_a.rs1_used_o, 0);
    chk("j_pending",   bus_a.pending_o, 8'h48);
    // JR rd=2 rs1=0 imm6=1F
    instr = 16'h7C16; pc = 16'h0106;
    #1 chk("jr_in_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("jr_opcode",   bus_a.opcode_o, 6);
    chk("jr_rd",       bus_a.rd_addr_o, 2);
    chk("jr_rs1",      bus_a.rs1_addr_o, 0);
    chk("jr_imm16",    bus_a.imm_data_o, 16'h001F);
    chk("jr_imm32",    bus_w.imm_data_o, 32'h0000_001F);
    chk("jr_rs1_used", bus_a.rs1_used_o, 1);
    chk("jr_pending",  bus_a.pending_o, 8'h4A);
    // drain, retire r3
    in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 3'd3;
    @(negedge clk);
    chk("wb3_pending",   bus_a.pending_o, 8'h46);
    chk("wb3_out_valid", bus_a.out_valid_o, 0);
    wb_addr = 3'd5;
    @(negedge clk);
    chk("wb_nonpend",    bus_a.pending_o, 8'h46);
    wb_valid = 1'b0;
    do_reset();

    // ---- RAW stall: I rd=5 then B rs1=5 rs2=4
    in_valid = 1'b1; instr = 16'h0069; pc = 16'h0200;
    #1 chk("raw_p_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("raw_p_valid", bus_a.out_valid_o, 1);
    chk("raw_p_rd",    bus_a.rd_addr_o, 5);
    instr = 16'h0364; pc = 16'h0202;
    #1;
    chk("raw_held_stall", bus_a.in_ready_o, 0);
    chk("nosb_no_stall",  bus_n.in_ready_o, 1);
    @(negedge clk);
    chk("raw_out_valid", bus_a.out_valid_o, 0);
    chk("raw_pending",   bus_a.pending_o, 8'h20);
    chk("raw_pend_stall", bus_a.in_ready_o, 0);
    chk("nosb_pending",  bus_n.pending_o, 0);
    @(negedge clk);
    chk("raw_still_stall", bus_a.in_ready_o, 0);
    wb_valid = 1'b1; wb_addr = 3'd5;
    #1 chk("raw_bypass_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("b_out_valid", bus_a.out_valid_o, 1);
    chk("b_opcode",    bus_a.opcode_o, 4);
    chk("b_rs1",       bus_a.rs1_addr_o, 5);
    chk("b_rs2",       bus_a.rs2_addr_o, 4);
    chk("b_func2",     bus_a.func2_o, 1);
    chk("b_rd_we",     bus_a.rd_we_o, 0);
    chk("b_rs2_used",  bus_a.rs2_used_o, 1);
    chk("b_pending",   bus_a.pending_o, 0);

    // ---- back-pressure: B held for 4 cycles, R rd=2 rs1=6 rs2=7 waiting
    out_ready = 1'b0; instr = 16'h3F90; pc = 16'h0204;
    #1 chk("bp_ready", bus_a.in_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid",  bus_a.out_valid_o, 1);
      chk("bp_opcode", bus_a.opcode_o, 4);
      chk("bp_rs1",    bus_a.rs1_addr_o, 5);
      chk("bp_rs2",    bus_a.rs2_addr_o, 4);
      chk("bp_pc",     bus_a.pc_o, 16'h0202);
      chk("bp_hold_ready", bus_a.in_ready_o, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("r2_valid", bus_a.out_valid_o, 1);
    chk("r2_rd",    bus_a.rd_addr_o, 2);
    chk("r2_pc",    bus_a.pc_o, 16'h0204);
    // consumer S rs2=2 imm=3 while R is held
    out_ready = 1'b0; instr = 16'h1813; pc = 16'h0206;
    #1 chk("s_held_ready", bus_a.in_ready_o, 0);
    @(negedge clk);
    chk("s_held_ready2", bus_a.in_ready_o, 0);
    out_ready = 1'b1;
    #1 chk("s_release_stall", bus_a.in_ready_o, 0);
    @(negedge clk);
    chk("s_out_valid", bus_a.out_valid_o, 0);
    chk("s_pending",   bus_a.pending_o, 8'h04);
    chk("s_pend_stall", bus_a.in_ready_o, 0);
    wb_valid = 1'b1; wb_addr = 3'd2;
    #1 chk("s_wb_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("s_valid",   bus_a.out_valid_o, 1);
    chk("s_opcode",  bus_a.opcode_o, 3);
    chk("s_rs2",     bus_a.rs2_addr_o, 2);
    chk("s_imm",     bus_a.imm_data_o, 16'h0003);
    chk("s_pend0",   bus_a.pending_o, 0);

    // ---- flush a held J rd=4
    instr = 16'h0025; pc = 16'h0208;
    #1 chk("fj_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("fj_valid",  bus_a.out_valid_o, 1);
    chk("fj_opcode", bus_a.opcode_o, 5);
    chk("fj_rd",     bus_a.rd_addr_o, 4);
    flush = 1'b1; instr = 16'h0069; pc = 16'h020A;
    #1 chk("flush_ready", bus_a.in_ready_o, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid",   bus_a.out_valid_o, 0);
    chk("flush_pending", bus_a.pending_o, 0);

    // ---- illegal opcode
    instr = 16'hFFFF; pc = 16'h020C;
    #1 chk("ill_ready", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("ill_flag",     bus_a.illegal_o, 1);
    chk("ill_opcode",   bus_a.opcode_o, 7);
    chk("ill_rd_we",    bus_a.rd_we_o, 0);
    chk("ill_rd",       bus_a.rd_addr_o, 0);
    chk("ill_rs1_used", bus_a.rs1_used_o, 0);
    chk("ill_imm",      bus_a.imm_data_o, 0);
    chk("ill_pc",       bus_a.pc_o, 16'h020C);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_pending",  bus_a.pending_o, 0);
    chk("ill_drained",  bus_a.out_valid_o, 0);

    // ---- zero register: I rd=0 then R rd=0 rs1=0 rs2=0
    in_valid = 1'b1; instr = 16'h0001; pc = 16'h0300;
    @(negedge clk);
    chk("z_valid", bus_a.out_valid_o, 1);
    chk("z_rd_we", bus_a.rd_we_o, 1);
    instr = 16'h0000; pc = 16'h0302;
    #1 chk("z_no_stall", bus_a.in_ready_o, 1);
    @(negedge clk);
    chk("z_pending", bus_a.pending_o, 0);
    chk("z_pc",      bus_a.pc_o, 16'h0302);
    in_valid = 1'b0;

    // ---- same-cycle set and clear of r5
    @(negedge clk);
    in_valid = 1'b1; instr = 16'h0069; pc = 16'h0400;
    @(negedge clk);
    in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 3'd5;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("setclr_pending", bus_a.pending_o, 8'h20);

    // ---- async reset mid-stall
    in_valid = 1'b1; instr = 16'h0364; pc = 16'h0402;
    #1 chk("mid_stall", bus_a.in_ready_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pending", bus_a.pending_o, 0);
    chk("arst_valid",   bus_a.out_valid_o, 0);
    chk("arst_rd",      bus_a.rd_addr_o, 0);
    chk("arst_pc",      bus_a.pc_o, 0);
    chk("arst_ready",   bus_a.in_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
